mem_io_arbiter: RTL
===================

Name: mem_io_arbiter

Overview:
- Shares the single-port data memory and the LED/switch IO window between two requesters: the CPU load/store path and the UART program loader, which is write-only.
- Sequences each access through a small FSM: grant, issue, wait for the memory read latency, then acknowledge.
- Decodes the IO region and owns the LED output register and the synchronised switch input.
- Sits between the execute/memory stage and the data memory block.

Parameters:
- IO_BASE, 32'hFFFF_FC00: addresses at or above this value are IO; all others are memory.
- LED_ADDR, 32'hFFFF_FC60: LED register, write-only, low 16 bits used.
- SW_ADDR, 32'hFFFF_FC70: switch register, read-only, zero-extended to 32 bits.
- MEM_RD_LAT, 1: data memory read latency in cycles; legal range 1..3.
- LD_BURST_MAX, 4: maximum consecutive loader grants while a CPU request is pending.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- cpu_req  in  1  CPU access request; held until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  load data; valid when cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- ld_req  in  1  loader write request; held until ld_ready
- ld_addr  in  32  loader address
- ld_wdata  in  32  loader data
- ld_ready  out  1  one-cycle completion pulse
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- sw_in  in  16  raw switch inputs
- led_out  out  16  LED drive

Behaviour:
- Reset (synchronous, rst_n low at a clk edge):
  - FSM goes to IDLE; burst counter and cpu_rdata clear to 0.
  - led_out, cpu_ready, ld_ready, mem_en and mem_we all clear to 0.
  - Reset asserted mid-access aborts the access: no ready pulse is produced and the memory is not written after reset.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE arbitration:
  - If only one requester is asserting, grant it.
  - If both are asserting, the loader wins unless burst_cnt == LD_BURST_MAX; in that case the CPU wins.
  - The grant and that requester's addr/we/wdata are latched, and the FSM moves to ISSUE.
  - burst_cnt increments on a loader grant while cpu_req is high. It clears on a CPU grant, and when a loader grant occurs with cpu_req low.
- ISSUE (one cycle):
  - Memory target: mem_en = 1, mem_we = latched we, mem_addr and mem_wdata from the latch.
  - IO target: mem_en = 0.
  - IO write to LED_ADDR: led_out <= wdata[15:0] at the end of ISSUE.
  - IO read of SW_ADDR: returns {16'b0, sw_sync}.
  - Unmapped IO address: reads return 0; writes are dropped.
  - Loader IO writes are ignored; the memory is not touched and ld_ready is still pulsed.
  - Next state: WAIT for a memory read, otherwise ACK.
- WAIT:
  - Counts MEM_RD_LAT cycles with mem_en = 0.
  - mem_rdata is captured into cpu_rdata at the edge ending the last WAIT cycle.
- ACK (one cycle):
  - The granted requester's ready pulses high.
  - cpu_rdata holds until the next CPU load completes.
  - Next state is IDLE.
- Latency, from the edge where the request is sampled in IDLE:
  - write or IO access: ready 2 cycles later;
  - memory read: ready 2+MEM_RD_LAT cycles later.
- Requesters keep addr/data stable until ready. A request still high in the cycle after ACK is treated as a new access.
- The switch input passes through a 2-flop synchroniser (sw_sync).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - Adds output port cpu_err (1 bit).
  - A CPU access with cpu_addr[1:0] != 0 performs no memory or IO side effect.
  - It completes with cpu_ready and cpu_err both pulsed in ACK, with the same latency as a write.
  - cpu_rdata is unchanged by a trapped access.
- When undefined: no cpu_err port, and the address bits [1:0] pass through unchanged.

Decomposition:
- Package mem_io_pkg holds:
  - IO_BASE, LED_ADDR and SW_ADDR defaults;
  - the FSM state enum (IDLE, ISSUE, WAIT, ACK);
  - the grant encoding (GNT_CPU, GNT_LD).
- One sub-module, io_regs, contains the LED register, the switch synchroniser and the IO read mux. The FSM and arbitration stay in the top module.

Test Plan:
- CPU store 32'h1234 to 0x10, then load 0x10 with MEM_RD_LAT = 1: the store's cpu_ready comes 2 cycles after its request; the load's cpu_ready comes 3 cycles after its request, with cpu_rdata = 32'h1234.
- CPU store 32'hABCD_5A5A to LED_ADDR: mem_en stays 0, led_out = 16'h5A5A, cpu_ready after 2 cycles.
- sw_in = 16'h00F3, wait 2 cycles, CPU load SW_ADDR: cpu_rdata = 32'h0000_00F3.
- Loader and CPU both requesting continuously:
  - grant order is LD, LD, LD, LD, CPU, then repeats;
  - with cpu_req low, the loader receives every grant.
- Assert rst_n = 0 during WAIT of a CPU load: no cpu_ready, led_out = 0, FSM in IDLE; a fresh load after reset completes normally.
- With MISALIGN_TRAP_EN defined, CPU store to 0x13: cpu_err and cpu_ready pulse together, mem_en never asserts, memory contents unchanged.

Source files
------------

// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared constants, FSM states and grant encoding for mem_io_arbiter
package mem_io_pkg;
    localparam logic [31:0] DEF_IO_BASE  = 32'hFFFF_FC00;
    localparam logic [31:0] DEF_LED_ADDR = 32'hFFFF_FC60;
    localparam logic [31:0] DEF_SW_ADDR  = 32'hFFFF_FC70;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    typedef enum logic {GNT_CPU, GNT_LD} gnt_t;
endpackage

// File: rtl/mem_io_arbiter_io_regs.sv
// io_regs: LED register, two-flop switch synchroniser and IO read mux
module io_regs
    import mem_io_pkg::*;
#(
    parameter logic [31:0] LED_ADDR = DEF_LED_ADDR,
    parameter logic [31:0] SW_ADDR  = DEF_SW_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [15:0] wdata,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic [31:0] rdata
);
    logic [15:0] sw_meta, sw_sync;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
            led_out <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (wr_en && addr == LED_ADDR) led_out <= wdata;
        end
    end
    assign rdata = addr == SW_ADDR ? {16'b0, sw_sync} : '0;
endmodule

// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: CPU/loader arbiter for data memory and LED/switch IO (optional MISALIGN_TRAP_EN)
module mem_io_arbiter
    import mem_io_pkg::*;
#(
    parameter logic [31:0] IO_BASE      = DEF_IO_BASE,
    parameter logic [31:0] LED_ADDR     = DEF_LED_ADDR,
    parameter logic [31:0] SW_ADDR      = DEF_SW_ADDR,
    parameter int          MEM_RD_LAT   = 1,
    parameter int          LD_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        cpu_err
`endif
);
    localparam int BW = $clog2(LD_BURST_MAX + 1);
    state_t      state;
    gnt_t        gnt;
    logic        lat_we, lat_trap, trap_in, ld_win, cpu_win, is_io, rd_mem, io_wr, to_ack;
    logic [31:0] lat_addr, lat_wdata, io_rdata;
    logic [BW-1:0] burst_cnt;
    logic [1:0]  wait_cnt;
`ifdef MISALIGN_TRAP_EN
    assign trap_in = cpu_addr[1:0] != 2'b00;
`else
    assign trap_in = 1'b0;
`endif
    assign ld_win    = ld_req && (!cpu_req || burst_cnt != BW'(LD_BURST_MAX));
    assign cpu_win   = cpu_req && !ld_win;
    assign is_io     = lat_addr >= IO_BASE;
    assign rd_mem    = !is_io && !lat_we && !lat_trap;
    assign mem_en    = state == ISSUE && !is_io && !lat_trap;
    assign mem_we    = mem_en && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign io_wr     = state == ISSUE && is_io && lat_we && gnt == GNT_CPU && !lat_trap;
    assign to_ack    = (state == ISSUE && !rd_mem) || (state == WAIT && wait_cnt == 2'(MEM_RD_LAT - 1));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= GNT_CPU;
            lat_we    <= 1'b0;
            lat_trap  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            burst_cnt <= '0;
            wait_cnt  <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            ld_ready  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            cpu_err   <= 1'b0;
`endif
        end else begin
            cpu_ready <= to_ack && gnt == GNT_CPU;
            ld_ready  <= to_ack && gnt == GNT_LD;
`ifdef MISALIGN_TRAP_EN
            cpu_err   <= to_ack && lat_trap;
`endif
            case (state)
                IDLE: if (ld_win || cpu_win) begin
                    gnt       <= ld_win ? GNT_LD : GNT_CPU;
                    lat_we    <= ld_win || cpu_we;
                    lat_addr  <= ld_win ? ld_addr : cpu_addr;
                    lat_wdata <= ld_win ? ld_wdata : cpu_wdata;
                    lat_trap  <= cpu_win && trap_in;
                    burst_cnt <= ld_win && cpu_req ? burst_cnt + 1'b1 : '0;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    if (is_io && !lat_we && !lat_trap) cpu_rdata <= io_rdata;
                    state <= rd_mem ? WAIT : ACK;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (to_ack) begin
                        cpu_rdata <= mem_rdata;
                        state     <= ACK;
                    end
                end
                ACK: state <= IDLE;
            endcase
        end
    end
    io_regs #(.LED_ADDR(LED_ADDR), .SW_ADDR(SW_ADDR)) u_io (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(io_wr),
        .addr(lat_addr),
        .wdata(lat_wdata[15:0]),
        .sw_in(sw_in),
        .led_out(led_out),
        .rdata(io_rdata)
    );
endmodule
